bcd_counter: RTL and testbench
==============================

BCD_COUNTER -- requirements
Module: bcd_counter

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per count increment (1 Hz at 100 MHz); legal range >=2.
REQ-002 Parameter SCAN_DIV, default 100000, clk cycles per display digit slot (1 kHz digit rate); legal range >=2.
REQ-003 Port clk, input, 1 bit: single clock, 100 MHz nominal, all state on rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port seg, output, 7 bits: segment cathodes, active-low, seg = {g,f,e,d,c,b,a}.
REQ-006 Port an, output, 4 bits: digit anodes, active-low one-hot; an[0] = units digit, an[3] = thousands digit.

Function
REQ-007 The design SHALL hold four BCD digits d3..d0 (thousands..units), each 4 bits and always in 0-9.
REQ-008 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0, raising a one-cycle tick in the cycle where it equals TICK_DIV-1.
REQ-009 On tick, d0 SHALL increment; a digit reaching 9 SHALL wrap to 0 and carry into the next digit in the same cycle.
REQ-010 On tick with count 9999, the count SHALL wrap to 0000 with no other side effect.
REQ-011 The scan counter SHALL count 0..SCAN_DIV-1; on its wrap, the 2-bit digit select SHALL advance 0->1->2->3->0.
REQ-012 For select s, an SHALL drive bit s low and the others high (s=0 -> 4'b1110, s=3 -> 4'b0111).
REQ-013 seg SHALL show the decode of digit ds: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-014 seg and an SHALL be registered, changing one clk cycle after the select or digit value they reflect changes.
REQ-015 A tick and a scan wrap in the same cycle SHALL both take effect; the displayed value follows one cycle later.

Reset
REQ-016 While rst_n=0: prescaler, scan counter, select and all digits = 0; an = 4'b1111; seg = 7'h7F.
REQ-017 Reset assertion SHALL take effect immediately without a clock edge, including mid-count and mid-scan.
REQ-018 On the first rising edge after rst_n rises: an = 4'b1110, seg = 7'h40, and the prescaler advances from 0.

Configuration
REQ-019 Macro BCD_COUNTER_BLANK_EN, when defined, SHALL enable leading-zero blanking.
REQ-020 With the macro defined, a digit that is zero and has only zero digits above it SHALL be blanked: its an bit stays high and seg = 7'h7F during its slot. d0 is never blanked.
REQ-021 Without the macro, all four digits SHALL always be displayed, including leading zeros.

Verification
REQ-022 Use TICK_DIV=4 and SCAN_DIV=2. Hold rst_n=0 for 3 cycles -> an=4'b1111, seg=7'h7F; release -> next edge an=4'b1110, seg=7'h40.
REQ-023 Run 10 ticks (40 cycles) -> count 0010; during the select=1 slot, seg=7'h79; during the select=0 slot, seg=7'h40.
REQ-024 Run to count 9999, then one more tick -> count 0000 and every slot shows seg=7'h40, without the macro.
REQ-025 Assert rst_n low mid-count at 0457, asynchronously between edges -> an=4'b1111 and seg=7'h7F immediately; after release, counting restarts at 0000.
REQ-026 With BCD_COUNTER_BLANK_EN defined at count 0042 -> slots 2 and 3 keep an high with seg=7'h7F; slot 1 shows seg=7'h19; slot 0 shows seg=7'h24.
REQ-027 Monitor across 8 scan wraps -> an is always one-hot-low (or all ones when blanked), and the select sequence is 0,1,2,3,0,1,2,3.

Source files
------------

// File: rtl/bcd_counter.sv
// bcd_counter: four-digit BCD up-counter driving a multiplexed active-low 7-segment display.
// Define BCD_COUNTER_BLANK_EN to blank leading zeros (units digit is always shown).
module bcd_counter #(
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [6:0] seg,
    output logic [3:0] an
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    logic [TW-1:0]     presc_q, presc_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0][3:0]   dig_q, dig_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        blank;
    logic              tick, scan_wrap, carry;
    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: dec = 7'h40;
            4'd1: dec = 7'h79;
            4'd2: dec = 7'h24;
            4'd3: dec = 7'h30;
            4'd4: dec = 7'h19;
            4'd5: dec = 7'h12;
            4'd6: dec = 7'h02;
            4'd7: dec = 7'h78;
            4'd8: dec = 7'h00;
            4'd9: dec = 7'h10;
            default: dec = 7'h7F;
        endcase
    endfunction
`ifdef BCD_COUNTER_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    assign blank = {dig_q[3] == 4'd0, dig_q[3:2] == 8'd0, dig_q[3:1] == 12'd0, 1'b0};
`else
    assign blank = '0;
`endif
    always_comb begin
        tick      = presc_q == TW'(TICK_DIV - 1);
        scan_wrap = scan_q == SW'(SCAN_DIV - 1);
        presc_d   = tick ? '0 : presc_q + 1'b1;
        scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
        sel_d     = scan_wrap ? sel_q + 2'd1 : sel_q;
        dig_d     = dig_q;
        carry     = tick;
        for (int i = 0; i < 4; i++) begin
            dig_d[i] = carry ? (dig_q[i] == 4'd9 ? 4'd0 : dig_q[i] + 4'd1) : dig_q[i];
            carry    = carry && dig_q[i] == 4'd9;
        end
        an_d  = blank[sel_q] ? 4'hF : ~(4'd1 << sel_q);
        seg_d = blank[sel_q] ? 7'h7F : dec(dig_q[sel_q]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            scan_q  <= '0;
            sel_q   <= '0;
            dig_q   <= '0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            dig_q   <= dig_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end
    assign seg = seg_q;
    assign an  = an_q;
endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: checks bcd_counter with TICK_DIV=4, SCAN_DIV=2 against a closed-form display model.
module tb_bcd_counter;
    localparam int TD = 4;
    localparam int SD = 2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    int         checks = 0;
    int         failures = 0;
    int         k = 0;
    logic [10:0] sb[$];
    typedef struct {
        int         k;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;
    vec_t tbl[22];
    always #5 clk = ~clk;
    bcd_counter #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an)
    );
    function automatic logic [6:0] dec(input int d);
        case (d)
            0: dec = 7'h40;
            1: dec = 7'h79;
            2: dec = 7'h24;
            3: dec = 7'h30;
            4: dec = 7'h19;
            5: dec = 7'h12;
            6: dec = 7'h02;
            7: dec = 7'h78;
            8: dec = 7'h00;
            9: dec = 7'h10;
            default: dec = 7'h7F;
        endcase
    endfunction
    // Outputs after edge k reflect select and count held after edge k-1.
    function automatic logic [10:0] model(input int kk);
        int j, sel, cnt, p;
        logic [3:0] a;
        j   = kk - 1;
        sel = (j / SD) % 4;
        cnt = (j / TD) % 10000;
        p   = 1;
        for (int i = 0; i < sel; i++) p = p * 10;
`ifdef BCD_COUNTER_BLANK_EN
        if (sel > 0 && cnt < p) return {4'hF, 7'h7F};
`endif
        a = ~(4'd1 << sel);
        return {a, dec((cnt / p) % 10)};
    endfunction
    function automatic vec_t v(input int kk, input logic [3:0] a, input logic [6:0] s, input bit bl);
        vec_t r;
        r.k   = kk;
        r.an  = a;
        r.seg = s;
`ifdef BCD_COUNTER_BLANK_EN
        if (bl) begin
            r.an  = 4'hF;
            r.seg = 7'h7F;
        end
`endif
        return r;
    endfunction
    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: an=%b seg=%h, expected an=%b seg=%h", name, act[10:7], act[6:0], exp[10:7], exp[6:0]);
        end
    endtask
    task automatic step();
        @(posedge clk);
        k++;
        sb.push_back(model(k));
        @(negedge clk);
        check($sformatf("scoreboard k=%0d", k), {an, seg}, sb.pop_front());
        checks++;
        if (!(an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1111})) begin
            failures++;
            $display("FAIL onehot k=%0d: an=%b, expected one-hot-low or 1111", k, an);
        end
    endtask
    task automatic run_to(input int target);
        while (k < target) step();
    endtask
    task automatic run_table(input int limit);
        for (int i = 0; i < 22; i++) begin
            if (tbl[i].k <= limit) begin
                run_to(tbl[i].k);
                check($sformatf("vector k=%0d", tbl[i].k), {an, seg}, {tbl[i].an, tbl[i].seg});
            end
        end
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", {an, seg}, {4'hF, 7'h7F});
        rst_n = 1'b1;
        k = 0;
        sb.delete();
    endtask
    initial begin
        tbl[0]  = v(1,     4'b1110, 7'h40, 0);
        tbl[1]  = v(3,     4'b1101, 7'h40, 1);
        tbl[2]  = v(5,     4'b1011, 7'h40, 1);
        tbl[3]  = v(7,     4'b0111, 7'h40, 1);
        tbl[4]  = v(41,    4'b1110, 7'h40, 0);
        tbl[5]  = v(43,    4'b1101, 7'h79, 0);
        tbl[6]  = v(45,    4'b1011, 7'h40, 1);
        tbl[7]  = v(49,    4'b1110, 7'h24, 0);
        tbl[8]  = v(51,    4'b1101, 7'h79, 0);
        tbl[9]  = v(169,   4'b1110, 7'h24, 0);
        tbl[10] = v(171,   4'b1101, 7'h19, 0);
        tbl[11] = v(173,   4'b1011, 7'h40, 1);
        tbl[12] = v(175,   4'b0111, 7'h40, 1);
        tbl[13] = v(493,   4'b1011, 7'h79, 0);
        tbl[14] = v(495,   4'b0111, 7'h40, 1);
        tbl[15] = v(1825,  4'b1110, 7'h02, 0);
        tbl[16] = v(1827,  4'b1101, 7'h12, 0);
        tbl[17] = v(39997, 4'b1011, 7'h10, 0);
        tbl[18] = v(39999, 4'b0111, 7'h10, 0);
        tbl[19] = v(40001, 4'b1110, 7'h40, 0);
        tbl[20] = v(40003, 4'b1101, 7'h40, 1);
        tbl[21] = v(40005, 4'b1011, 7'h40, 1);
        do_reset();
        run_table(1830);
        run_to(1830);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {an, seg}, {4'hF, 7'h7F});
        do_reset();
        run_table(40005);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
